// File: rtl/hack_io_pkg.sv
// Shared definitions for the Hack memory-mapped I/O blocks: status bit
// positions, SPI FSM states and SPI pin reset levels.
package hack_io_pkg;

    localparam int SPI_BUSY_BIT = 15;
    localparam int SPI_CEN_BIT  = 8;
    localparam int SPI_DIV_BIT  = 9;

    localparam logic SPI_MOSI_RST = 1'b1;
    localparam logic SPI_CEN_RST  = 1'b1;

    typedef enum logic [1:0] {
        SPI_IDLE = 2'd0,
        SPI_LOW  = 2'd1,
        SPI_HIGH = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_clk_div.sv
// SCK half-period counter: reloads on i_restart and raises o_tick while the
// count sits at zero. A divider of 0 behaves as 1.
module spi_clk_div (
    input  logic       clk_in,
    input  logic       reset_n,
    input  logic       i_restart,
    input  logic [7:0] i_div,
    output logic       o_tick
);

    logic [7:0] r_cnt;
    logic [7:0] w_load;

    assign w_load = (i_div == 8'd0) ? 8'd0 : i_div - 8'd1;
    assign o_tick = (r_cnt == 8'd0);

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= 8'd0;
        end else if (i_restart) begin
            r_cnt <= w_load;
        end else if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

endmodule

// File: rtl/hack_spi_master.sv
// Memory-mapped SPI master (mode 0, MSB first) for the Hack CPU driving an SD card.
// Define SPI_DIV_REG_EN to make the SCK divider writable through in[9].
module hack_spi_master
    import hack_io_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic        clk_in,
    input  logic        reset_n,
    input  logic        load,
    input  logic [15:0] in,
    output logic [15:0] out,
    input  logic        sd_miso,
    output logic        sd_mosi,
    output logic        sd_sck,
    output logic        sd_cen
);

    spi_state_e r_state, w_state_nxt;

    logic       r_sck;
    logic       r_mosi;
    logic       r_cen;
    logic       r_busy;
    logic [7:0] r_tx;
    logic [7:0] r_rx_sh;
    logic [7:0] r_rx;
    logic [2:0] r_bit;
    logic [7:0] w_div;

    logic w_idle_wr;
    logic w_div_wr;
    logic w_desel;
    logic w_start;
    logic w_tick;
    logic w_rise;
    logic w_fall;
    logic w_last;
    logic w_restart;

    assign w_idle_wr = load && (r_state == SPI_IDLE);

`ifdef SPI_DIV_REG_EN
    logic [7:0] r_div;

    assign w_div_wr = w_idle_wr && in[SPI_DIV_BIT];
    assign w_div    = r_div;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= 8'(CLK_DIV);
        end else if (w_div_wr) begin
            r_div <= in[7:0];
        end
    end
`else
    assign w_div_wr = 1'b0;
    assign w_div    = 8'(CLK_DIV);
`endif

    assign w_desel = w_idle_wr && !w_div_wr && in[SPI_CEN_BIT];
    assign w_start = w_idle_wr && !w_div_wr && !in[SPI_CEN_BIT];

    assign w_rise    = (r_state == SPI_LOW)  && w_tick;
    assign w_fall    = (r_state == SPI_HIGH) && w_tick;
    assign w_last    = w_fall && (r_bit == 3'd7);
    assign w_restart = w_start || w_rise || (w_fall && !w_last);

    spi_clk_div u_clk_div (
        .clk_in    (clk_in),
        .reset_n   (reset_n),
        .i_restart (w_restart),
        .i_div     (w_div),
        .o_tick    (w_tick)
    );

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= SPI_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SPI_IDLE: if (w_start) w_state_nxt = SPI_LOW;
            SPI_LOW:  if (w_tick)  w_state_nxt = SPI_HIGH;
            SPI_HIGH: if (w_tick)  w_state_nxt = (r_bit == 3'd7) ? SPI_IDLE : SPI_LOW;
            default:  w_state_nxt = SPI_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_sck   <= 1'b0;
            r_mosi  <= SPI_MOSI_RST;
            r_cen   <= SPI_CEN_RST;
            r_busy  <= 1'b0;
            r_tx    <= 8'd0;
            r_rx_sh <= 8'd0;
            r_rx    <= 8'd0;
            r_bit   <= 3'd0;
        end else begin
            if (w_desel) begin
                r_cen <= 1'b1;
            end
            if (w_start) begin
                r_cen   <= 1'b0;
                r_busy  <= 1'b1;
                r_tx    <= in[7:0];
                r_mosi  <= in[7];
                r_rx_sh <= 8'd0;
                r_bit   <= 3'd0;
            end
            if (w_rise) begin
                r_sck   <= 1'b1;
                r_rx_sh <= {r_rx_sh[6:0], sd_miso};
            end
            if (w_fall) begin
                r_sck <= 1'b0;
                r_tx  <= {r_tx[6:0], 1'b0};
                r_bit <= r_bit + 3'd1;
                // The last falling edge parks MOSI high instead of shifting.
                r_mosi <= w_last ? SPI_MOSI_RST : r_tx[6];
            end
            if (w_last) begin
                r_busy <= 1'b0;
                r_rx   <= r_rx_sh;
            end
        end
    end

    assign sd_sck  = r_sck;
    assign sd_mosi = r_mosi;
    assign sd_cen  = r_cen;
    assign out     = {r_busy, 6'd0, r_cen, r_rx};

endmodule

// File: tb/tb_hack_spi_master.sv
// Directed self-checking bench for hack_spi_master (default CLK_DIV=16).
module tb_hack_spi_master;

    logic        clk_in = 1'b0;
    logic        reset_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] din = 16'd0;
    logic [15:0] dout;
    logic        sd_miso;
    logic        sd_mosi;
    logic        sd_sck;
    logic        sd_cen;
    logic        loopback = 1'b1;
    logic        miso_val = 1'b0;

    int n_run = 0;
    int n_fail = 0;

    assign sd_miso = loopback ? ~sd_mosi : miso_val;

    always #5 clk_in = ~clk_in;

    hack_spi_master dut (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .load    (load),
        .in      (din),
        .out     (dout),
        .sd_miso (sd_miso),
        .sd_mosi (sd_mosi),
        .sd_sck  (sd_sck),
        .sd_cen  (sd_cen)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [15:0] w);
        din = w;
        load = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        load = 1'b0;
    endtask

    // Starts a transfer and runs it to completion, optionally injecting a
    // write at busy cycle inj_at. Called and returning on a falling clock edge.
    task automatic xfer(input string tag, input logic [15:0] w, input int inj_at,
                        input logic [15:0] inj, output int ncyc, output int nrise,
                        output int first_rise, output logic [7:0] bits);
        logic prev_sck;
        ncyc = 0;
        nrise = 0;
        first_rise = -1;
        bits = 8'd0;
        wr(w);
        check({tag, "_start_busy"}, 32'(dout[15]), 32'd1);
        check({tag, "_start_cen"},  32'(sd_cen), 32'd0);
        check({tag, "_start_mosi"}, 32'(sd_mosi), 32'(w[7]));
        prev_sck = sd_sck;
        for (int t = 0; t < 5000 && dout[15]; t++) begin
            ncyc++;
            if (ncyc == inj_at) begin
                din = inj;
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            @(posedge clk_in);
            @(negedge clk_in);
            if (!prev_sck && sd_sck) begin
                bits = {bits[6:0], sd_mosi};
                nrise++;
                if (first_rise < 0) first_rise = ncyc;
            end
            prev_sck = sd_sck;
        end
        load = 1'b0;
    endtask

    initial begin
        int ncyc, nrise, fr, sck_edges;
        logic [7:0] bits;
        logic prev;

        @(negedge clk_in);
        repeat (3) @(negedge clk_in);
        check("rst_sck",  32'(sd_sck), 32'd0);
        check("rst_mosi", 32'(sd_mosi), 32'd1);
        check("rst_cen",  32'(sd_cen), 32'd1);
        check("rst_out",  32'(dout), 32'h0100);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_in);
        check("idle_out", 32'(dout), 32'h0100);
        check("idle_sck", 32'(sd_sck), 32'd0);

        // Loopback transfer with an ignored write mid-flight
        xfer("a5", 16'h00A5, 100, 16'h0033, ncyc, nrise, fr, bits);
        check("a5_busy_cyc", 32'(ncyc), 32'd256);
        check("a5_rises",    32'(nrise), 32'd8);
        check("a5_first_rise", 32'(fr), 32'd16);
        check("a5_mosi_bits", 32'(bits), 32'hA5);
        check("a5_out",      32'(dout), 32'h005A);
        check("a5_cen",      32'(sd_cen), 32'd0);
        check("a5_mosi_idle", 32'(sd_mosi), 32'd1);

        // Back-to-back: start on the first cycle busy reads 0
        xfer("3c", 16'h003C, 0, 16'h0, ncyc, nrise, fr, bits);
        check("3c_busy_cyc", 32'(ncyc), 32'd256);
        check("3c_mosi_bits", 32'(bits), 32'h3C);
        check("3c_out",      32'(dout), 32'h00C3);

        // Deselect: CEN high, no SCK activity, rx byte kept
        wr(16'h0100);
        check("desel_cen", 32'(sd_cen), 32'd1);
        check("desel_out", 32'(dout), 32'h01C3);
        sck_edges = 0;
        prev = sd_sck;
        repeat (40) begin
            @(negedge clk_in);
            if (sd_sck != prev) sck_edges++;
            prev = sd_sck;
        end
        check("desel_sck_quiet", 32'(sck_edges), 32'd0);

`ifdef SPI_DIV_REG_EN
        wr(16'h0202);
        check("div2_wr_out", 32'(dout), 32'h01C3);
        loopback = 1'b0;
        miso_val = 1'b0;
        xfer("ff", 16'h00FF, 0, 16'h0, ncyc, nrise, fr, bits);
        check("ff_busy_cyc", 32'(ncyc), 32'd32);
        check("ff_rx",       32'(dout[7:0]), 32'h00);
        loopback = 1'b1;
        wr(16'h0200);
        xfer("81", 16'h0081, 0, 16'h0, ncyc, nrise, fr, bits);
        check("div0_busy_cyc", 32'(ncyc), 32'd16);
        check("div0_rx",       32'(dout), 32'h007E);
        wr(16'h0210);
`else
        // in[9] is not decoded: 0x0202 is an ordinary transfer of 0x02
        xfer("nodiv", 16'h0202, 0, 16'h0, ncyc, nrise, fr, bits);
        check("nodiv_busy_cyc", 32'(ncyc), 32'd256);
        check("nodiv_out",      32'(dout), 32'h00FD);
`endif

        // Async reset during the 3rd SCK high phase
        wr(16'h00A5);
        nrise = 0;
        prev = sd_sck;
        for (int t = 0; t < 2000 && nrise < 3; t++) begin
            @(negedge clk_in);
            if (!prev && sd_sck) nrise++;
            prev = sd_sck;
        end
        check("arst_reached_3rd_high", 32'(nrise), 32'd3);
        #2 reset_n = 1'b0;
        #1;
        check("arst_sck",  32'(sd_sck), 32'd0);
        check("arst_mosi", 32'(sd_mosi), 32'd1);
        check("arst_cen",  32'(sd_cen), 32'd1);
        check("arst_out",  32'(dout), 32'h0100);
        @(negedge clk_in);
        reset_n = 1'b1;
        repeat (40) @(negedge clk_in);
        check("arst_idle_out", 32'(dout), 32'h0100);
        check("arst_idle_sck", 32'(sd_sck), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
